// File: rtl/booth_radix4_seq_if.sv
// Handshake and operand bus between the controlling logic and the radix-4 Booth multiplier.
// The master owns start and the operands; the multiplier drives product/busy/done back.
interface booth_radix4_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mcand_neg;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, mcand, mcand_neg, mplier,
    input  product, busy, done
  );

  modport slave (
    input  start, mcand, mcand_neg, mplier,
    output product, busy, done
  );
endinterface

// File: rtl/booth_radix4_seq.sv
// Sequential signed radix-4 Booth multiplier: retires two multiplier bits per cycle,
// using the externally supplied two's complement of the multiplicand as the -M operand.
module booth_radix4_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_radix4_seq_if.slave   bus
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int AW   = WIDTH + 2;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [AW-1:0]        m_ext, neg_ext, addend, sum;
  logic [AW+WIDTH:0]    cat, cat_sh;

  // The most-negative multiplicand has no representable W-bit negation, so its
  // +2^(W-1) is rebuilt here by zero-extending instead of sign-extending.
  always_comb begin
    m_ext   = {{2{m_q[WIDTH-1]}}, m_q};
    neg_ext = (m_q == MOST_NEG) ? {2'b00, neg_q} : {{2{neg_q[WIDTH-1]}}, neg_q};
    unique case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = neg_ext << 1;
      3'b101, 3'b110: addend = neg_ext;
      default:        addend = '0;
    endcase
    sum    = a_q + addend;
    cat    = {sum, q_q, qm1_q};
    cat_sh = {{2{sum[AW-1]}}, cat[AW+WIDTH:2]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    neg_d     = neg_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = CALC;
          m_d     = bus.mcand;
          neg_d   = bus.mcand_neg;
          a_d     = '0;
          q_d     = bus.mplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        {a_d, q_d, qm1_d} = cat_sh;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_d == CW'(HALF)) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      m_q       <= '0;
      neg_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_booth_radix4_seq.sv
// Directed bench for booth_radix4_seq (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_booth_radix4_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  booth_radix4_seq_if #(.WIDTH(W)) bus ();

  booth_radix4_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stands in for the upstream complement_2 stage.
  assign bus.mcand_neg = ~bus.mcand + 1'b1;

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Samples on negedges starting with the current one until done is seen.
  task automatic wait_done(output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  bc;
    bit  ok;
    int  dcnt;
    logic [2*W-1:0] pcap;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hF9, 8'h06, 16'hFFD6};
    vecs[2] = '{8'h80, 8'h80, 16'h4000};
    vecs[3] = '{8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{8'h04, 8'h04, 16'h0010};
    vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[7] = '{8'h80, 8'h7F, 16'hC080};
    vecs[8] = '{8'h00, 8'hFB, 16'h0000};
    vecs[9] = '{8'h01, 8'h80, 16'hFF80};

    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", 32'(bus.product), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(bc, ok);
      chk($sformatf("vec%0d_done_seen", i), 32'(ok), 32'h1);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd4);
      chk($sformatf("vec%0d_product", i), 32'(bus.product), 32'(vecs[i].p));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse_width", i), 32'(bus.done), 32'h0);
      chk($sformatf("vec%0d_product_held", i), 32'(bus.product), 32'(vecs[i].p));
    end

    // start while busy must be ignored
    issue(8'h03, 8'h05);
    @(negedge clk);
    bus.mcand  = 8'h02;
    bus.mplier = 8'h02;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    dcnt = 0;
    pcap = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        dcnt++;
        pcap = bus.product;
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(dcnt), 32'd1);
    chk("ignore_product", 32'(pcap), 32'h000F);
    chk("ignore_busy_idle", 32'(bus.busy), 32'h0);

    // reset mid-iteration discards everything
    issue(8'h03, 8'h05);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk("midrst_product", 32'(bus.product), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h04, 8'h04);
    wait_done(bc, ok);
    chk("postrst_done_seen", 32'(ok), 32'h1);
    chk("postrst_busy_cycles", 32'(bc), 32'd4);
    chk("postrst_product", 32'(bus.product), 32'h0010);

    // back-to-back: start accepted in the DONE cycle
    issue(8'h03, 8'h05);
    wait_done(bc, ok);
    chk("b2b_first_done_seen", 32'(ok), 32'h1);
    chk("b2b_first_product", 32'(bus.product), 32'h000F);
    bus.mcand  = 8'hFF;
    bus.mplier = 8'hFF;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    chk("b2b_done_one_cycle", 32'(bus.done), 32'h0);
    chk("b2b_busy_rises", 32'(bus.busy), 32'h1);
    wait_done(bc, ok);
    chk("b2b_second_done_seen", 32'(ok), 32'h1);
    chk("b2b_busy_between", 32'(bc), 32'd4);
    chk("b2b_second_product", 32'(bus.product), 32'h0001);
    @(negedge clk);
    chk("b2b_second_done_width", 32'(bus.done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
